stochastic_deserializer_mc: RTL
===============================

Name: stochastic_deserializer_mc

Overview:
Multi-channel, length-parametrised stochastic-to-binary converter. It counts the ones in CHANNELS parallel serial bitstreams over a window of 2^LEN_LOG2 clock cycles. It returns each count as a unipolar value (count) or a bipolar value (2*count - 2^LEN_LOG2). It sits at the output of the stochastic arithmetic datapath and hands results to binary logic through a valid/ready handshake. Count width covers the all-ones stream with no overflow.

Parameters:
CHANNELS, 4, number of independent bitstreams
LEN_LOG2, 10, window length is 2^LEN_LOG2 bits; legal range 2..16
RW, LEN_LOG2+2, per-channel result width (derived, not overridable)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a new window (aborts any window in progress)
bipolar  in  1  mode, sampled only at start: 0 = unipolar, 1 = bipolar
ser_in  in  CHANNELS  bit i is the serial stream of channel i
busy  out  1  high while a window is accumulating
res  out  CHANNELS*RW  channel i in bits [i*RW +: RW]; two's complement
res_valid  out  1  result available
res_ready  in  1  consumer accepts result

Behaviour:
- One clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values:
  - state = IDLE
  - busy = 0, res_valid = 0, res = 0
  - all counters 0, mode register 0
- FSM states: IDLE, ACCUM, HOLD.
- start in any state, at edge E0:
  - clear sample counter and all channel counts
  - latch bipolar into mode register
  - next state ACCUM; busy = 1; res_valid = 0
  - ser_in is NOT sampled at E0
- ACCUM:
  - edges E1..E(2^LEN_LOG2) each sample ser_in
  - channel count increments when its bit is 1
  - sample counter is LEN_LOG2 bits and runs 0..2^L-1; it wraps to 0 exactly on the last sample
- Last sample edge E(2^L):
  - res is loaded from count + final bit (final bit included)
  - res_valid = 1, busy = 0, state = HOLD
  - latency is start edge to res_valid edge = 2^L edges
- Result arithmetic, c = final count in [0, 2^L] (L+1 bits):
  - unipolar: res_i = zero-extended c
  - bipolar: res_i = 2c - 2^L, range [-2^L, +2^L], sign-extended to RW
- HOLD:
  - res and res_valid stable until accepted
  - res_valid & res_ready at an edge -> IDLE; res_valid = 0; res retains its value
- Simultaneous events:
  - start has priority over res_ready in HOLD: the result is dropped, res_valid falls, new window begins
  - start during ACCUM restarts from zero; no partial result is emitted
- res_ready is ignored when res_valid = 0. ser_in is ignored outside ACCUM.
- rst_n low mid-window: immediate return to reset values; no result is emitted.
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Package stoch_pkg holds:
  - typedef of the mode enum (MODE_UNIPOLAR = 0, MODE_BIPOLAR = 1)
  - FSM state enum (IDLE/ACCUM/HOLD)
  - function res_width(len_log2) = len_log2 + 2
- Sub-module stoch_ch_counter, one per channel via generate:
  - inputs: clk, rst_n, clear, en, bit, mode, capture
  - output: RW-bit registered result (includes final bit on capture)
- The top holds the FSM, sample counter, mode register and handshake.

Test Plan:
- LEN_LOG2=4, CHANNELS=4, unipolar, ch0 all-ones, ch1 all-zeros, ch2 alternating 1010, ch3 single 1 on the last sample -> res_valid after 16 edges; res = {1, 8, 0, 16}; busy low on the same edge.
- Same streams with bipolar=1 -> res = {-14, 0, -16, +16}; ch2 reads 0, ch0 reads +16 with no overflow.
- Default LEN_LOG2=10, ch0 all-ones -> res0 = 1024 (0x400), res_valid exactly 1024 edges after start.
- HOLD with res_ready low for 5 cycles, then high for 1 -> res stable through the hold; res_valid falls on the accept edge; state IDLE.
- start at sample 7 of an ACCUM window, then start again in HOLD while res_ready=1 -> neither window's partial/old result is accepted; a new window completes with counts from the final window only.
- rst_n pulsed low mid-ACCUM (asynchronous, between edges) -> busy, res_valid, res drop to 0 immediately; a subsequent start produces a correct result.

Source files
------------

// File: rtl/stochastic_deserializer_mc_pkg.sv
// Shared types for the stochastic-to-binary deserializer.
// Mode and FSM encodings plus the result-width helper.
package stoch_pkg;

    typedef enum logic {
        MODE_UNIPOLAR = 1'b0,
        MODE_BIPOLAR  = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // Width that holds 2^L (unipolar) and -2^L..+2^L (bipolar).
    function automatic int res_width(input int len_log2);
        return len_log2 + 2;
    endfunction

endpackage

// File: rtl/stochastic_deserializer_mc_if.sv
// Window-control and result-handshake bundle of the deserializer.
// master: the deserializer; slave: the producer/consumer side.
interface stochastic_deserializer_mc_if
    import stoch_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int LEN_LOG2 = 10
);
    localparam int RW = res_width(LEN_LOG2);

    logic                   start;
    logic                   bipolar;
    logic [CHANNELS-1:0]    ser_in;
    logic                   busy;
    logic [CHANNELS*RW-1:0] res;
    logic                   res_valid;
    logic                   res_ready;

    modport master (
        input  start,
        input  bipolar,
        input  ser_in,
        input  res_ready,
        output busy,
        output res,
        output res_valid
    );

    modport slave (
        output start,
        output bipolar,
        output ser_in,
        output res_ready,
        input  busy,
        input  res,
        input  res_valid
    );

endinterface

// File: rtl/stochastic_deserializer_mc_ch_counter.sv
// One channel: counts ones over the window and scales the total
// into a unipolar or bipolar result on the capture edge.
module stoch_ch_counter
    import stoch_pkg::*;
#(
    parameter  int LEN_LOG2 = 10,
    localparam int RW       = res_width(LEN_LOG2)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          en,
    input  logic          ser_bit,
    input  mode_e         mode,
    input  logic          capture,
    output logic [RW-1:0] res
);

    logic [LEN_LOG2:0] cnt_q;
    logic [LEN_LOG2:0] total;
    logic [RW-1:0]     uni;
    logic [RW-1:0]     bip;

    // The final sample is folded in here so capture sees the full count.
    assign total = cnt_q + {{LEN_LOG2{1'b0}}, ser_bit};
    assign uni   = {1'b0, total};
    assign bip   = {total, 1'b0} - (RW'(1) << LEN_LOG2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            res   <= '0;
        end else begin
            if (clear) begin
                cnt_q <= '0;
            end else if (en) begin
                cnt_q <= total;
            end
            if (capture) begin
                res <= (mode == MODE_BIPOLAR) ? bip : uni;
            end
        end
    end

endmodule

// File: rtl/stochastic_deserializer_mc.sv
// Multi-channel stochastic-to-binary converter: window FSM,
// sample counter, mode register and result handshake.
module stochastic_deserializer_mc
    import stoch_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int LEN_LOG2 = 10
) (
    input logic clk,
    input logic rst_n,
    stochastic_deserializer_mc_if.master bus
);

    localparam int RW = res_width(LEN_LOG2);

    state_e                 state_q;
    state_e                 state_d;
    logic [LEN_LOG2-1:0]    smp_q;
    mode_e                  mode_q;
    logic                   busy_q;
    logic                   valid_q;
    logic                   en;
    logic                   last_smp;
    logic                   capture;
    logic [CHANNELS*RW-1:0] res_w;

    assign last_smp = (smp_q == '1);
    assign en       = (state_q == ACCUM) && !bus.start;
    assign capture  = en && last_smp;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = IDLE;
            ACCUM:   if (last_smp) state_d = HOLD;
            HOLD:    if (bus.res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A new window overrides both completion and acceptance.
        if (bus.start) begin
            state_d = ACCUM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == ACCUM);
            valid_q <= (state_d == HOLD);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_q  <= '0;
            mode_q <= MODE_UNIPOLAR;
        end else if (bus.start) begin
            smp_q  <= '0;
            mode_q <= mode_e'(bus.bipolar);
        end else if (en) begin
            smp_q  <= smp_q + LEN_LOG2'(1);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        stoch_ch_counter #(
            .LEN_LOG2 (LEN_LOG2)
        ) u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .clear   (bus.start),
            .en      (en),
            .ser_bit (bus.ser_in[i]),
            .mode    (mode_q),
            .capture (capture),
            .res     (res_w[i*RW +: RW])
        );
    end

    assign bus.busy      = busy_q;
    assign bus.res_valid = valid_q;
    assign bus.res       = res_w;

endmodule
